ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED "set LEDs", or 0xFF "reset") from the FPGA to the keyboard on the same PS2_CLK/PS2_DAT pair that the keyboard receiver listens on. It performs the bus inhibit and request-to-send sequence, shifts out the data bits, parity and stop bit on device-generated clocks, and checks the device acknowledge. It drives the bus only through open-drain pull-low enables. `tx_busy` lets the top level tell the receiver to ignore traffic while a command is in flight.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_line_filter.sv | 44 ++++
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device command path.
// Also used by the keyboard receiver side of the bus.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_FIRST,
    SHIFT,
    WAIT_IDLE
  } ps2_state_e;

  // 50 MHz timing: 120 us inhibit, 15 ms to first device clock, 2 ms per frame.
  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_START_TIMEOUT  = 750000;
  localparam int DEF_FRAME_TIMEOUT  = 100000;
  localparam int DEF_FILTER_LEN     = 8;

  localparam logic [3:0] PARITY_IDX = 4'd8;
  localparam logic [3:0] STOP_IDX   = 4'd9;
  localparam logic [3:0] ACK_IDX    = 4'd10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the user logic (master) and ps2_host_tx (slave).
interface ps2_host_tx_if;
  import ps2_pkg::*;

  // tx_start is a one-cycle request honoured only while the FSM is IDLE, and
  // tx_data is captured on that cycle. Every accepted request ends with exactly
  // one tx_done pulse; tx_nack/tx_timeout are valid with it and hold until the
  // next accept. tx_busy covers the cycle after accept through the tx_done cycle.
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_nack;
  logic        tx_timeout;
  ps2_state_e  dbg_state;

  modport master (
    output tx_data, tx_start,
    input  tx_busy, tx_done, tx_nack, tx_timeout, dbg_state
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_busy, tx_done, tx_nack, tx_timeout, dbg_state
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizer plus FILTER_LEN-sample glitch filter for one PS/2 line, with a
// one-cycle pulse on every filtered 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int RW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [RW-1:0] RUN_LAST = RW'(FILTER_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic [RW-1:0] run_cnt;

  // Bus idles high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      run_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 == level) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        level   <= sync2;
        run_cnt <= '0;
        fall    <= ~sync2;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data
// bits + odd parity + stop on device clocks, then ack check. Open-drain outputs.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int FRAME_TIMEOUT  = DEF_FRAME_TIMEOUT,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_dat_in,
  output logic           ps2_clk_oe,
  output logic           ps2_dat_oe
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > FRAME_TIMEOUT) ? MAX_AB : FRAME_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_TIMEOUT - 1);

  logic clk_level, clk_fall, dat_level, dat_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(CLOCK_50), .rst(reset), .pin(ps2_clk_in), .level(clk_level), .fall(clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk(CLOCK_50), .rst(reset), .pin(ps2_dat_in), .level(dat_level), .fall(dat_fall_unused)
  );

  ps2_state_e    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    bit_idx, bit_idx_d;
  logic [7:0]    data, data_d;
  logic          parity, parity_d;
  logic          clk_oe_d, dat_oe_d;
  logic          busy, busy_d;
  logic          done, done_d;
  logic          nack, nack_d;
  logic          timeout, timeout_d;
  logic          abort;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= '0;
      parity     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      data       <= data_d;
      parity     <= parity_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
      busy       <= busy_d;
      done       <= done_d;
      nack       <= nack_d;
      timeout    <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    data_d    = data;
    parity_d  = parity;
    clk_oe_d  = ps2_clk_oe;
    dat_oe_d  = ps2_dat_oe;
    busy_d    = busy;
    done_d    = 1'b0;
    nack_d    = nack;
    timeout_d = timeout;
    abort     = 1'b0;

    case (state)
      IDLE: begin
        busy_d   = 1'b0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx.tx_start) begin
          data_d    = tx.tx_data;
          parity_d  = odd_parity(tx.tx_data);
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          clk_oe_d  = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == INH_LAST) begin
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = RTS;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RTS: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        // The first device fall is bit slot 0; it also starts the frame timer.
        if (cnt == START_LAST) begin
          abort = 1'b1;
        end else if (clk_fall) begin
          dat_oe_d  = ~data[0];
          bit_idx_d = 4'd1;
          cnt_d     = '0;
          state_d   = SHIFT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = cnt + 1'b1;
        if (cnt == FRAME_LAST) begin
          abort = 1'b1;
        end else if (clk_fall) begin
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx < PARITY_IDX) begin
            dat_oe_d = ~data[bit_idx[2:0]];
          end else if (bit_idx == PARITY_IDX) begin
            dat_oe_d = ~parity;
          end else if (bit_idx == STOP_IDX) begin
            dat_oe_d = 1'b0;
          end else begin
            // Ack edge (ACK_IDX): device should be holding data low.
            nack_d  = dat_level;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = cnt + 1'b1;
        if (cnt == FRAME_LAST) begin
          abort = 1'b1;
        end else if (clk_level && dat_level) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      clk_oe_d  = 1'b0;
      dat_oe_d  = 1'b0;
      timeout_d = 1'b1;
      done_d    = 1'b1;
      cnt_d     = '0;
      state_d   = IDLE;
    end
  end

  assign tx.tx_busy    = busy;
  assign tx.tx_done    = done;
  assign tx.tx_nack    = nack;
  assign tx.tx_timeout = timeout;
  assign tx.dbg_state  = state;

endmodule
